// File: rtl/round_key_sequencer.sv
// Round-key sequencer: captures one full expanded-key set and streams it one
// round key per handshake, ascending for encryption or descending for decryption.
module round_key_sequencer #(
  parameter int unsigned NUM_ROUNDS_P = 14,
  parameter int unsigned KEY_WIDTH_P  = 128
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [0:KEY_WIDTH_P*(NUM_ROUNDS_P+1)-1]      round_keys_i,
  input  logic                                         decrypt_i,
  input  logic                                         v_i,
  output logic                                         ready_o,
  output logic [0:KEY_WIDTH_P-1]                       key_o,
  output logic [3:0]                                   round_o,
  output logic                                         last_o,
  output logic                                         v_o,
  input  logic                                         yumi_i
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS_P + 1;
  localparam int unsigned ROUND_W  = 4;
  localparam logic [ROUND_W-1:0] LAST_BEAT = ROUND_W'(NUM_ROUNDS_P);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 v_q, v_d;
  logic                 last_q, last_d;
  logic                 dec_q, dec_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [ROUND_W-1:0]   beat_q, beat_d;
  logic                 load_c;
  logic [KEY_WIDTH_P-1:0] bank_q [NUM_KEYS];

  // Control state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
      dec_q   <= 1'b0;
      round_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      v_q     <= v_d;
      last_q  <= last_d;
      dec_q   <= dec_d;
      round_q <= round_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    v_d     = v_q;
    last_d  = last_q;
    dec_d   = dec_q;
    round_d = round_q;
    beat_d  = beat_q;
    load_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        v_d     = 1'b0;
        // ready_q gates acceptance so the first post-reset cycle never loads
        if (v_i && ready_q) begin
          load_c  = 1'b1;
          dec_d   = decrypt_i;
          round_d = decrypt_i ? LAST_BEAT : '0;
          beat_d  = '0;
          last_d  = (LAST_BEAT == '0);
          ready_d = 1'b0;
          v_d     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        ready_d = 1'b0;
        v_d     = 1'b1;
        if (yumi_i) begin
          if (last_q) begin
            ready_d = 1'b1;
            v_d     = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            round_d = dec_q ? (round_q - ROUND_W'(1)) : (round_q + ROUND_W'(1));
            beat_d  = beat_q + ROUND_W'(1);
            last_d  = ((beat_q + ROUND_W'(1)) == LAST_BEAT);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Key bank; key 0 sits at the MSB end of the flattened input
  always_ff @(posedge clk_i) begin
    if (load_c) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        bank_q[k] <= round_keys_i[KEY_WIDTH_P*k +: KEY_WIDTH_P];
      end
    end
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign last_o  = last_q;
  assign round_o = round_q;
  assign key_o   = bank_q[round_q];

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench for round_key_sequencer: randomized handshakes compared
// against a key-set model with its own AES-256 key expansion.
module tb_round_key_sequencer;

  localparam int unsigned NR = 14;
  localparam int unsigned KW = 128;
  localparam int unsigned NK = NR + 1;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [0:KW*NK-1]  round_keys_i = '0;
  logic              decrypt_i = 1'b0;
  logic              v_i = 1'b0;
  logic              ready_o;
  logic [0:KW-1]     key_o;
  logic [3:0]        round_o;
  logic              last_o;
  logic              v_o;
  logic              yumi_i = 1'b0;

  round_key_sequencer #(.NUM_ROUNDS_P(NR), .KEY_WIDTH_P(KW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .round_keys_i(round_keys_i),
    .decrypt_i(decrypt_i), .v_i(v_i), .ready_o(ready_o), .key_o(key_o),
    .round_o(round_o), .last_o(last_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [127:0] sets [3][NK];
  logic [7:0]   sbox_t [256];

  logic [127:0] obs_key [NK+1];
  logic [3:0]   obs_round [NK+1];
  logic         obs_last [NK+1];
  int           obs_n, obs_cyc, stab_err, busy_ready;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // AES-256 key schedule into sets[1]
  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < int'(NK); r++) sets[1][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic drive_set(input int s, input logic dec);
    for (int k = 0; k < int'(NK); k++) round_keys_i[KW*k +: KW] = sets[s][k];
    decrypt_i = dec;
  endtask

  task automatic load();
    int n = 0;
    while (!ready_o && n < 50) begin tick(); n++; end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL load_ready: ready_o=%b after %0d cycles, required 1", ready_o, n);
    end
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
  endtask

  // Consumes up to maxb beats with yumi_i at prob percent; records what it saw
  task automatic collect(input int maxb, input int prob);
    logic         pv = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pr = '0;
    logic         pl = 1'b0;
    obs_n = 0; obs_cyc = 0; stab_err = 0; busy_ready = 0;
    while (obs_n < maxb && obs_cyc < 300) begin
      if (v_o) begin
        if (pv && (key_o !== pk || round_o !== pr || last_o !== pl)) stab_err++;
        if (ready_o) busy_ready++;
        yumi_i = ($urandom_range(99) < prob);
        if (yumi_i) begin
          obs_key[obs_n] = key_o; obs_round[obs_n] = round_o; obs_last[obs_n] = last_o;
          obs_n++;
          pv = 1'b0;
        end else begin
          pv = 1'b1; pk = key_o; pr = round_o; pl = last_o;
        end
      end else begin
        yumi_i = 1'b0;
        pv = 1'b0;
      end
      tick();
      obs_cyc++;
    end
    yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b0 || round_o !== 4'd0 || last_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: v=%b ready=%b round=%0d last=%b, required 0 0 0 0",
               v_o, ready_o, round_o, last_o);
    end
    reset_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ready_o !== 1'b1 || v_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: ready=%b v=%b, required 1 0", i, ready_o, v_o);
      end
      tick();
    end
  endtask

  task automatic test_ascending();
    drive_set(0, 1'b0);
    load();
    checks++;
    if (v_o !== 1'b1 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL asc_latency: v=%b ready=%b, required 1 0", v_o, ready_o);
    end
    collect(NK, 100);
    checks++;
    if (obs_n != int'(NK) || obs_cyc != int'(NK)) begin
      failures++;
      $display("FAIL asc_count: beats=%0d cycles=%0d, required %0d %0d", obs_n, obs_cyc, NK, NK);
    end
    for (int i = 0; i < obs_n; i++) begin
      checks++;
      if (obs_round[i] !== 4'(i) || obs_key[i] !== {16{8'(i)}} || obs_last[i] !== (i == int'(NR))) begin
        failures++;
        $display("FAIL asc_beat[%0d]: round=%0d key=%h last=%b, required %0d %h %b",
                 i, obs_round[i], obs_key[i], obs_last[i], i, {16{8'(i)}}, (i == int'(NR)));
      end
    end
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL asc_return: v=%b ready=%b, required 0 1", v_o, ready_o);
    end
  endtask

  task automatic test_descending_fips();
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    drive_set(1, 1'b1);
    load();
    collect(NK, 100);
    checks++;
    if (obs_round[0] !== 4'd14 || obs_key[0] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      failures++;
      $display("FAIL fips_first: round=%0d key=%h, required 14 24fc79ccbf0979e9371ac23c6d68de36",
               obs_round[0], obs_key[0]);
    end
    checks++;
    if (obs_round[NR] !== 4'd0 || obs_key[NR] !== 128'h000102030405060708090a0b0c0d0e0f ||
        obs_last[NR] !== 1'b1) begin
      failures++;
      $display("FAIL fips_last: round=%0d key=%h last=%b, required 0 000102030405060708090a0b0c0d0e0f 1",
               obs_round[NR], obs_key[NR], obs_last[NR]);
    end
    for (int i = 0; i < int'(NK); i++) begin
      checks++;
      if (obs_round[i] !== 4'(NR - i) || obs_key[i] !== sets[1][NR-i]) begin
        failures++;
        $display("FAIL desc_beat[%0d]: round=%0d key=%h, required %0d %h",
                 i, obs_round[i], obs_key[i], NR - i, sets[1][NR-i]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive_set(0, 1'b0);
    load();
    collect(NK, 30);
    checks++;
    if (stab_err != 0 || obs_n != int'(NK)) begin
      failures++;
      $display("FAIL bp_stable: unstable=%0d beats=%0d, required 0 %0d", stab_err, obs_n, NK);
    end
    for (int i = 0; i < obs_n; i++) begin
      checks++;
      if (obs_round[i] !== 4'(i) || obs_key[i] !== sets[0][i] || obs_last[i] !== (i == int'(NR))) begin
        failures++;
        $display("FAIL bp_beat[%0d]: round=%0d key=%h last=%b, required %0d %h %b",
                 i, obs_round[i], obs_key[i], obs_last[i], i, sets[0][i], (i == int'(NR)));
      end
    end
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_return: v=%b ready=%b, required 0 1", v_o, ready_o);
    end
  endtask

  task automatic test_busy_ignore();
    for (int k = 0; k < int'(NK); k++) sets[2][k] = {$urandom, $urandom, $urandom, $urandom};
    drive_set(0, 1'b0);
    load();
    drive_set(2, 1'b1);
    v_i = 1'b1;
    collect(NK, 70);
    checks++;
    if (busy_ready != 0 || obs_n != int'(NK)) begin
      failures++;
      $display("FAIL busy_ready: ready_high_cycles=%0d beats=%0d, required 0 %0d", busy_ready, obs_n, NK);
    end
    for (int i = 0; i < obs_n; i++) begin
      checks++;
      if (obs_round[i] !== 4'(i) || obs_key[i] !== sets[0][i]) begin
        failures++;
        $display("FAIL busy_first[%0d]: round=%0d key=%h, required %0d %h",
                 i, obs_round[i], obs_key[i], i, sets[0][i]);
      end
    end
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_return: ready=%b v=%b, required 1 0", ready_o, v_o);
    end
    tick();
    v_i = 1'b0;
    collect(NK, 100);
    for (int i = 0; i < int'(NK); i++) begin
      checks++;
      if (obs_round[i] !== 4'(NR - i) || obs_key[i] !== sets[2][NR-i]) begin
        failures++;
        $display("FAIL busy_second[%0d]: round=%0d key=%h, required %0d %h",
                 i, obs_round[i], obs_key[i], NR - i, sets[2][NR-i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_set(2, 1'b0);
    load();
    collect(6, 100);
    checks++;
    if (round_o !== 4'd6 || obs_round[5] !== 4'd5 || obs_key[5] !== sets[2][5]) begin
      failures++;
      $display("FAIL mid_progress: round=%0d last_taken=%0d, required 6 5", round_o, obs_round[5]);
    end
    reset_i = 1'b1;
    tick();
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: v=%b ready=%b, required 0 0", v_o, ready_o);
    end
    reset_i = 1'b0;
    tick();
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || round_o !== 4'd0) begin
      failures++;
      $display("FAIL mid_after: v=%b ready=%b round=%0d, required 0 1 0", v_o, ready_o, round_o);
    end
    yumi_i = 1'b1;
    repeat (2) tick();
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || round_o !== 4'd0 || last_o !== 1'b0) begin
      failures++;
      $display("FAIL stray_yumi: v=%b ready=%b round=%0d last=%b, required 0 1 0 0",
               v_o, ready_o, round_o, last_o);
    end
    drive_set(0, 1'b0);
    load();
    collect(NK, 100);
    for (int i = 0; i < int'(NK); i++) begin
      checks++;
      if (obs_round[i] !== 4'(i) || obs_key[i] !== sets[0][i] || obs_last[i] !== (i == int'(NR))) begin
        failures++;
        $display("FAIL mid_restream[%0d]: round=%0d key=%h last=%b, required %0d %h %b",
                 i, obs_round[i], obs_key[i], obs_last[i], i, sets[0][i], (i == int'(NR)));
      end
    end
  endtask

  initial begin
    build_sbox();
    for (int k = 0; k < int'(NK); k++) sets[0][k] = {16{8'(k)}};
    test_reset();
    test_ascending();
    test_descending_fips();
    test_backpressure();
    test_busy_ignore();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Reader side of the AES-256 key-expansion output.
- Accepts one flattened set of 15 round keys (1920 bits) via a valid/ready handshake and stores it locally.
- Streams the keys one 128-bit key per handshake to the cipher/decipher round datapath.
- Order is ascending (round 0..14) for encryption or descending (round 14..0) for decryption, so the expansion pipeline is freed after a single transfer.

Parameters:
- NUM_ROUNDS_P, 14, number of cipher rounds; the block stores NUM_ROUNDS_P+1 round keys.
- KEY_WIDTH_P, 128, width of one round key in bits.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- round_keys_i  input  [0:KEY_WIDTH_P*(NUM_ROUNDS_P+1)-1]  flattened keys; key k occupies bits [KEY_WIDTH_P*k : KEY_WIDTH_P*k+KEY_WIDTH_P-1]; key 0 at MSB end.
- decrypt_i  input  1  order select, sampled with round_keys_i on accept; 0 = ascending, 1 = descending.
- v_i  input  1  input set valid.
- ready_o  output  1  block can accept a set.
- key_o  output  [0:KEY_WIDTH_P-1]  current round key.
- round_o  output  4  index (0..NUM_ROUNDS_P) of the key on key_o.
- last_o  output  1  current beat is the final key of the set.
- v_o  output  1  key_o, round_o and last_o are valid.
- yumi_i  input  1  consumer takes the current beat; legal only while v_o=1.

Behaviour:
- States: IDLE, STREAM. One clock domain; all flops update on the rising edge of clk_i.
- Reset:
  - While reset_i=1: state to IDLE, ready_o=0, v_o=0, last_o=0, round_o=0, beat counter=0.
  - The key bank is not reset; key_o is don't-care while v_o=0.
  - First cycle after reset_i falls: ready_o=1.
- IDLE:
  - ready_o=1, v_o=0.
  - When v_i=1, all round keys and decrypt_i are captured into the bank and mode register.
  - round_o is set to 0 (ascending) or NUM_ROUNDS_P (descending), beat counter to 0, and state moves to STREAM.
  - v_i=0: hold state.
- STREAM:
  - ready_o=0 and v_o=1, including the final beat. Input sets are never accepted here; v_i is ignored.
  - key_o = bank[round_o], read combinationally from registers.
  - last_o = (beat counter == NUM_ROUNDS_P).
  - yumi_i=0: key_o, round_o and last_o hold stable.
  - yumi_i=1 with last_o=0: round_o steps by +1 (ascending) or -1 (descending) and the beat counter increments; the next key appears the following cycle. This gives one key per cycle under continuous yumi_i.
  - yumi_i=1 with last_o=1: return to IDLE; v_o=0 and ready_o=1 the next cycle.
- Latency: first key valid on the cycle after the accepting v_i&ready_o edge.
- Throughput: NUM_ROUNDS_P+1 beats plus 1 IDLE cycle per set, i.e. 16 cycles minimum for AES-256.
- round_o never wraps. It stays within 0..NUM_ROUNDS_P because the beat counter ends the stream first. Its 4-bit width covers NUM_ROUNDS_P up to 15.
- yumi_i while v_o=0 is a protocol violation with no effect on state.
- Reset mid-stream: the remaining beats are discarded, and the block returns to IDLE with ready_o=1 on the first cycle after reset.
- No combinational path from v_i or yumi_i to ready_o or v_o: both are pure functions of state.

Test Plan:
- Reset, then idle: during reset v_o=0 and ready_o=0; the cycle after, ready_o=1 and v_o=0. Holds for 10 idle cycles with v_i=0.
- Ascending, yumi_i held high: load key k = 16 copies of byte k (key 0 = all 00, key 14 = all 0E) with decrypt_i=0.
  - Expect 15 consecutive v_o beats; round_o goes 0..14 and key_o = repeated byte round_o.
  - last_o=1 only on round_o=14; ready_o=1 exactly one cycle after the last beat.
- Descending, FIPS-197 AES-256 key 000102..1f, expansion supplied by reference model, decrypt_i=1:
  - First beat round_o=14, key_o = 24fc79ccbf0979e9371ac23c6d68de36.
  - Last beat round_o=0, key_o = 000102030405060708090a0b0c0d0e0f, last_o=1.
- Backpressure: yumi_i random at 30% during the ascending pattern.
  - key_o, round_o and last_o stay stable while yumi_i=0.
  - No beats are dropped or duplicated; 15 beats total.
- Input ignored while busy: drive v_i=1 with a different pattern during STREAM.
  - ready_o=0 throughout and the streamed keys remain from the first set.
  - The second set is accepted only once ready_o returns to 1.
- Reset mid-stream and stray yumi_i:
  - Assert reset_i after round_o=5 → v_o=0; next set streams from round_o=0.
  - yumi_i pulsed while v_o=0 → no state change.
